// File: rtl/event_counter_bank_pkg.sv
// Shared constants and snapshot state encoding for the event counter bank.
package event_counter_bank_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_t;

endpackage

// File: rtl/event_counter_bank_if.sv
// Control/data bundle between the counter bank and its producer/consumer side.
interface event_counter_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 14
);
  logic [CHANNELS-1:0]       Enable;
  logic [CHANNELS-1:0]       Dir;
  logic [CHANNELS-1:0]       Saturate;
  logic [CHANNELS-1:0]       Load;
  logic [CHANNELS*WIDTH-1:0] LoadValue;
  logic [CHANNELS*WIDTH-1:0] Limit;
  logic [CHANNELS-1:0]       ClearOverflow;
  logic                      Snapshot;
  logic                      SnapAck;
  logic [CHANNELS*WIDTH-1:0] Count;
  logic [CHANNELS-1:0]       TerminalPulse;
  logic [CHANNELS-1:0]       Overflow;
  logic                      SnapValid;
  logic [CHANNELS*WIDTH-1:0] SnapData;

  modport master (
    output Enable, Dir, Saturate, Load, LoadValue, Limit, ClearOverflow, Snapshot, SnapAck,
    input  Count, TerminalPulse, Overflow, SnapValid, SnapData
  );

  modport slave (
    input  Enable, Dir, Saturate, Load, LoadValue, Limit, ClearOverflow, Snapshot, SnapAck,
    output Count, TerminalPulse, Overflow, SnapValid, SnapData
  );
endinterface

// File: rtl/event_counter_bank_counter_channel.sv
// One up/down counter with load, live limit compare, wrap/saturate,
// registered terminal pulse and sticky overflow flag.
module counter_channel
  import event_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 14
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             saturate,
  input  logic             load,
  input  logic             clear_overflow,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal_pulse,
  output logic             overflow
);

  logic [WIDTH-1:0] count_next;
  logic             event_c;

  // Next count and terminal-event detection; load outranks a step.
  always_comb begin
    count_next = count;
    event_c    = 1'b0;
    if (load) begin
      count_next = (load_value > limit) ? limit : load_value;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        if (count < limit) begin
          count_next = WIDTH'(count + 1'b1);
        end else begin
          // A count left above a lowered limit is treated as at-limit.
          event_c    = 1'b1;
          count_next = (saturate == MODE_SAT) ? limit : '0;
        end
      end else begin
        if (count != '0) begin
          count_next = WIDTH'(count - 1'b1);
        end else begin
          event_c    = 1'b1;
          count_next = (saturate == MODE_SAT) ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count          <= '0;
      terminal_pulse <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      count          <= count_next;
      terminal_pulse <= event_c;
      // Set beats clear when both happen on the same edge.
      if (event_c) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters with a coherent snapshot handshake.
module event_counter_bank
  import event_counter_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 14
) (
  input logic                 Clock,
  input logic                 Reset,
  event_counter_bank_if.slave bus
);

  logic [CHANNELS*WIDTH-1:0] count_flat;
  logic [CHANNELS-1:0]       pulse_vec;
  logic [CHANNELS-1:0]       ovf_vec;
  logic [CHANNELS*WIDTH-1:0] snap_data;
  snap_state_t               state;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
    counter_channel #(.WIDTH(WIDTH)) u_chan (
      .Clock          (Clock),
      .Reset          (Reset),
      .enable         (bus.Enable[i]),
      .dir            (bus.Dir[i]),
      .saturate       (bus.Saturate[i]),
      .load           (bus.Load[i]),
      .clear_overflow (bus.ClearOverflow[i]),
      .load_value     (bus.LoadValue[i*WIDTH +: WIDTH]),
      .limit          (bus.Limit[i*WIDTH +: WIDTH]),
      .count          (count_flat[i*WIDTH +: WIDTH]),
      .terminal_pulse (pulse_vec[i]),
      .overflow       (ovf_vec[i])
    );
  end

  // Snapshot FSM: captures the pre-step count registers of the capture edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= SNAP_IDLE;
      snap_data <= '0;
    end else begin
      case (state)
        SNAP_IDLE: begin
          if (bus.Snapshot) begin
            snap_data <= count_flat;
            state     <= SNAP_HOLD;
          end
        end
        SNAP_HOLD: begin
          if (bus.SnapAck) begin
            if (bus.Snapshot) begin
              snap_data <= count_flat;
            end else begin
              state <= SNAP_IDLE;
            end
          end
        end
        default: state <= SNAP_IDLE;
      endcase
    end
  end

  assign bus.Count         = count_flat;
  assign bus.TerminalPulse = pulse_vec;
  assign bus.Overflow      = ovf_vec;
  assign bus.SnapData      = snap_data;
  assign bus.SnapValid     = (state == SNAP_HOLD);

endmodule

// File: tb/tb_event_counter_bank.sv
// Self-checking bench: directed table on channel 0, snapshot/reset sequences,
// then random stimulus against a behavioural model of the whole bank.
module tb_event_counter_bank;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 14;
  localparam int unsigned NRAND = 600;

  logic Clock = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  event_counter_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  event_counter_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         dir;
    logic         sat;
    logic [W-1:0] lim;
    logic         clr;
    logic [W-1:0] ec;
    logic         ep;
    logic         eo;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int unsigned m_count[CH];
  bit          m_pulse[CH];
  bit          m_ovf[CH];
  int unsigned m_snap[CH];
  bit          m_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Enable = '0; bus.Dir = '0; bus.Saturate = '0; bus.Load = '0;
    bus.LoadValue = '0; bus.Limit = '0; bus.ClearOverflow = '0;
    bus.Snapshot = 1'b0; bus.SnapAck = 1'b0;
  endtask

  function automatic vec_t mk(input logic ld, input int lv, input logic en, input logic dir,
                              input logic sat, input int lim, input logic clr,
                              input int ec, input logic ep, input logic eo);
    vec_t v;
    v.ld = ld; v.lv = W'(lv); v.en = en; v.dir = dir; v.sat = sat;
    v.lim = W'(lim); v.clr = clr; v.ec = W'(ec); v.ep = ep; v.eo = eo;
    return v;
  endfunction

  // Model step from the specification rules, using the inputs about to be sampled.
  task automatic model_step();
    int unsigned lim, lv;
    bit ev;
    if (Reset) begin
      m_valid = 1'b0;
      for (int i = 0; i < int'(CH); i++) m_snap[i] = 0;
    end else if (!m_valid && bus.Snapshot) begin
      m_valid = 1'b1;
      for (int i = 0; i < int'(CH); i++) m_snap[i] = m_count[i];
    end else if (m_valid && bus.SnapAck) begin
      if (bus.Snapshot) for (int i = 0; i < int'(CH); i++) m_snap[i] = m_count[i];
      else m_valid = 1'b0;
    end
    for (int i = 0; i < int'(CH); i++) begin
      lim = int'(bus.Limit[i*W +: W]);
      lv  = int'(bus.LoadValue[i*W +: W]);
      ev  = 1'b0;
      if (Reset) begin
        m_count[i] = 0; m_pulse[i] = 0; m_ovf[i] = 0;
      end else begin
        if (bus.Load[i]) m_count[i] = (lv < lim) ? lv : lim;
        else if (bus.Enable[i]) begin
          if (bus.Dir[i]) begin
            if (m_count[i] < lim) m_count[i] = m_count[i] + 1;
            else begin ev = 1; m_count[i] = bus.Saturate[i] ? lim : 0; end
          end else begin
            if (m_count[i] > 0) m_count[i] = m_count[i] - 1;
            else begin ev = 1; m_count[i] = bus.Saturate[i] ? 0 : lim; end
          end
        end
        m_pulse[i] = ev;
        if (ev) m_ovf[i] = 1;
        else if (bus.ClearOverflow[i]) m_ovf[i] = 0;
      end
    end
  endtask

  task automatic compare_model();
    logic [CH*W-1:0] ec, es;
    logic [CH-1:0]   ep, eo;
    for (int i = 0; i < int'(CH); i++) begin
      ec[i*W +: W] = W'(m_count[i]);
      es[i*W +: W] = W'(m_snap[i]);
      ep[i] = m_pulse[i];
      eo[i] = m_ovf[i];
    end
    check("rnd_count",    64'(bus.Count),         64'(ec));
    check("rnd_pulse",    64'(bus.TerminalPulse), 64'(ep));
    check("rnd_overflow", 64'(bus.Overflow),      64'(eo));
    check("rnd_snapvalid", 64'(bus.SnapValid),    64'(m_valid));
    check("rnd_snapdata", 64'(bus.SnapData),      64'(es));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},     64'(bus.Count),         64'd0);
    check({tag, "_pulse"},     64'(bus.TerminalPulse), 64'd0);
    check({tag, "_overflow"},  64'(bus.Overflow),      64'd0);
    check({tag, "_snapvalid"}, 64'(bus.SnapValid),     64'd0);
    check({tag, "_snapdata"},  64'(bus.SnapData),      64'd0);
  endtask

  initial begin
    // Channel 0 directed vectors: ld lv en dir sat lim clr | count pulse ovf
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    1, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    2, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    3, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    4, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    5, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    0, 1, 1));
    vecs.push_back(mk(0,    0, 1, 1, 0,    5, 0,    1, 0, 1));
    vecs.push_back(mk(0,    0, 0, 1, 0,    5, 1,    1, 0, 0));
    vecs.push_back(mk(1,    2, 0, 0, 1,    5, 0,    2, 0, 0));
    vecs.push_back(mk(0,    0, 1, 0, 1,    5, 0,    1, 0, 0));
    vecs.push_back(mk(0,    0, 1, 0, 1,    5, 0,    0, 0, 0));
    vecs.push_back(mk(0,    0, 1, 0, 1,    5, 0,    0, 1, 1));
    vecs.push_back(mk(0,    0, 1, 0, 1,    5, 0,    0, 1, 1));
    vecs.push_back(mk(1, 9000, 0, 1, 0, 1000, 0, 1000, 0, 1));
    vecs.push_back(mk(1,    7, 1, 1, 0, 1000, 0,    7, 0, 1));
    vecs.push_back(mk(1, 1000, 0, 1, 0, 1000, 0, 1000, 0, 1));
    vecs.push_back(mk(0,    0, 1, 1, 0, 1000, 1,    0, 1, 1));
    vecs.push_back(mk(0,    0, 0, 1, 0, 1000, 1,    0, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 1,    0, 0,    0, 1, 1));
    vecs.push_back(mk(0,    0, 1, 0, 0,    0, 0,    0, 1, 1));
    vecs.push_back(mk(1,   10, 0, 1, 0,   20, 1,   10, 0, 0));
    vecs.push_back(mk(0,    0, 1, 1, 0,    4, 0,    0, 1, 1));

    idle_inputs();
    Reset = 1'b1;
    tick();
    check_all_zero("reset");
    Reset = 1'b0;

    foreach (vecs[k]) begin
      idle_inputs();
      bus.Load[0] = vecs[k].ld;          bus.LoadValue[W-1:0] = vecs[k].lv;
      bus.Enable[0] = vecs[k].en;        bus.Dir[0] = vecs[k].dir;
      bus.Saturate[0] = vecs[k].sat;     bus.Limit[W-1:0] = vecs[k].lim;
      bus.ClearOverflow[0] = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_count", k),    64'(bus.Count[W-1:0]),   64'(vecs[k].ec));
      check($sformatf("vec%0d_pulse", k),    64'(bus.TerminalPulse[0]), 64'(vecs[k].ep));
      check($sformatf("vec%0d_overflow", k), 64'(bus.Overflow[0]),    64'(vecs[k].eo));
    end

    // Snapshot handshake while channel 0 steps upward.
    idle_inputs();
    bus.Limit[W-1:0] = W'(100);
    bus.Load[0] = 1'b1; bus.LoadValue[W-1:0] = W'(3);
    tick();
    check("snap_preload", 64'(bus.Count[W-1:0]), 64'd3);
    bus.Load[0] = 1'b0; bus.Enable[0] = 1'b1; bus.Dir[0] = 1'b1; bus.Snapshot = 1'b1;
    tick();
    check("snap_data_first", 64'(bus.SnapData[W-1:0]), 64'd3);
    check("snap_valid_rise", 64'(bus.SnapValid), 64'd1);
    check("snap_count_step", 64'(bus.Count[W-1:0]), 64'd4);
    tick();
    check("snap_hold_data",  64'(bus.SnapData[W-1:0]), 64'd3);
    check("snap_hold_valid", 64'(bus.SnapValid), 64'd1);
    bus.Snapshot = 1'b0; bus.SnapAck = 1'b1;
    tick();
    check("snap_ack_fall", 64'(bus.SnapValid), 64'd0);
    bus.SnapAck = 1'b0; bus.Snapshot = 1'b1;
    tick();
    check("snap_second_data",  64'(bus.SnapData[W-1:0]), 64'd6);
    check("snap_second_valid", 64'(bus.SnapValid), 64'd1);
    bus.Snapshot = 1'b0; bus.ClearOverflow = '0;
    Reset = 1'b1;
    tick();
    check_all_zero("midreset");
    Reset = 1'b0;

    // Random phase against the model, starting from the reset state.
    for (int i = 0; i < int'(CH); i++) begin
      m_count[i] = 0; m_pulse[i] = 0; m_ovf[i] = 0; m_snap[i] = 0;
    end
    m_valid = 1'b0;
    idle_inputs();
    for (int i = 0; i < int'(CH); i++) bus.Limit[i*W +: W] = W'($urandom_range(0, 12));
    for (int n = 0; n < int'(NRAND); n++) begin
      Reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < int'(CH); i++) begin
        bus.Enable[i]        = ($urandom_range(0, 3) != 0);
        bus.Dir[i]           = 1'($urandom_range(0, 1));
        bus.Saturate[i]      = 1'($urandom_range(0, 1));
        bus.Load[i]          = ($urandom_range(0, 9) == 0);
        bus.ClearOverflow[i] = ($urandom_range(0, 7) == 0);
        bus.LoadValue[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
        if ($urandom_range(0, 15) == 0) bus.Limit[i*W +: W] = W'($urandom_range(0, 12));
      end
      bus.Snapshot = 1'($urandom_range(0, 1));
      bus.SnapAck  = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      compare_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
